// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC generator: branch counter encodings,
// instruction size and the saturating counter update.
package pc_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam int INSN_BYTES = 4;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST)  ? ST  : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer: combinational lookup port plus a
// clocked training port driven by the resolved branch from EX.
module btb
  import pc_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int TAG_W    = 26,
  parameter int TGT_W    = 30
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [IDX_BITS-1:0] i_lk_idx,
  input  logic [TAG_W-1:0]    i_lk_tag,
  output logic                o_lk_hit,
  output logic [1:0]          o_lk_ctr,
  output logic [TGT_W-1:0]    o_lk_tgt,
  input  logic                i_up_en,
  input  logic                i_up_taken,
  input  logic [IDX_BITS-1:0] i_up_idx,
  input  logic [TAG_W-1:0]    i_up_tag,
  input  logic [TGT_W-1:0]    i_up_tgt
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic             r_valid [ENTRIES];
  logic [TAG_W-1:0] r_tag   [ENTRIES];
  logic [TGT_W-1:0] r_tgt   [ENTRIES];
  logic [1:0]       r_ctr   [ENTRIES];

  logic w_up_hit;

  // Lookup reads the registered arrays, so a same-cycle update is not seen yet.
  assign o_lk_hit = r_valid[i_lk_idx] && (r_tag[i_lk_idx] == i_lk_tag);
  assign o_lk_ctr = r_ctr[i_lk_idx];
  assign o_lk_tgt = r_tgt[i_lk_idx];

  assign w_up_hit = r_valid[i_up_idx] && (r_tag[i_up_idx] == i_up_tag);

  always_ff @(posedge clk) begin
    if (rst_) begin
      for (int e = 0; e < ENTRIES; e++) begin
        r_valid[e] <= 1'b0;
        r_ctr[e]   <= WNT;
      end
    end else if (i_up_en) begin
      if (w_up_hit) begin
        r_ctr[i_up_idx] <= ctr_next(r_ctr[i_up_idx], i_up_taken);
        if (i_up_taken) r_tgt[i_up_idx] <= i_up_tgt;
      end else if (i_up_taken) begin
        // Miss-taken allocation evicts whatever aliased entry lived here.
        r_valid[i_up_idx] <= 1'b1;
        r_tag[i_up_idx]   <= i_up_tag;
        r_tgt[i_up_idx]   <= i_up_tgt;
        r_ctr[i_up_idx]   <= WT;
      end
    end
  end

endmodule

// File: rtl/pc_gen_btb.sv
// IF-stage fetch PC generator with BTB prediction; redirect priority is
// reset > flush > stall > predicted-taken > sequential.
module pc_gen_btb
  import pc_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VEC    = 32'h0000_0000,
  parameter int               BTB_IDX_BITS = 4
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_flush,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam int TAG_W   = XLEN - BTB_IDX_BITS - 2;
  localparam int TGT_W   = XLEN - 2;
  localparam int PC_STEP = INSN_BYTES / 4;

  // Only the word address is stored, so pc[1:0] is structurally zero.
  logic [TGT_W-1:0] r_pc_hi;
  logic [TGT_W-1:0] w_pc_next;
  logic             w_lk_hit;
  logic [1:0]       w_lk_ctr;
  logic [TGT_W-1:0] w_lk_tgt;
  logic             w_pred_taken;
  logic             w_unused_bits;

  btb #(
    .IDX_BITS (BTB_IDX_BITS),
    .TAG_W    (TAG_W),
    .TGT_W    (TGT_W)
  ) u_btb (
    .clk        (clk),
    .rst_       (rst_),
    .i_lk_idx   (r_pc_hi[BTB_IDX_BITS-1:0]),
    .i_lk_tag   (r_pc_hi[TGT_W-1:BTB_IDX_BITS]),
    .o_lk_hit   (w_lk_hit),
    .o_lk_ctr   (w_lk_ctr),
    .o_lk_tgt   (w_lk_tgt),
    .i_up_en    (upd_valid),
    .i_up_taken (upd_taken),
    .i_up_idx   (upd_pc[BTB_IDX_BITS+1:2]),
    .i_up_tag   (upd_pc[XLEN-1:BTB_IDX_BITS+2]),
    .i_up_tgt   (upd_target[XLEN-1:2])
  );

  assign w_pred_taken = w_lk_hit && w_lk_ctr[1];

  always_comb begin
    w_pc_next = r_pc_hi + TGT_W'(PC_STEP);
    if (flush)             w_pc_next = pc_flush[XLEN-1:2];
    else if (stall)        w_pc_next = r_pc_hi;
    else if (w_pred_taken) w_pc_next = w_lk_tgt;
  end

  always_ff @(posedge clk) begin
    if (rst_) r_pc_hi <= RESET_VEC[XLEN-1:2];
    else      r_pc_hi <= w_pc_next;
  end

  assign pc          = {r_pc_hi, 2'b00};
  assign pred_taken  = w_pred_taken;
  assign pred_target = w_pred_taken ? {w_lk_tgt, 2'b00} : '0;

  // Byte-offset bits of the address inputs and ctr[0] carry no information here.
  assign w_unused_bits = ^{pc_flush[1:0], upd_pc[1:0], upd_target[1:0], w_lk_ctr[0]};

endmodule

// File: tb/tb_pc_gen_btb.sv
// Bench for pc_gen_btb: two instances (reset vectors 0 and 0xFFFF_FFFC) share
// stimulus and are compared every cycle against a behavioural model.
module tb_pc_gen_btb;

  logic        clk;
  logic        rst_;
  logic        stall;
  logic        flush;
  logic [31:0] pc_flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc0, ptg0, pc1, ptg1;
  logic        pt0, pt1;

  int n_pass  = 0;
  int n_total = 0;

  pc_gen_btb #(.XLEN(32), .RESET_VEC(32'h0000_0000), .BTB_IDX_BITS(4)) dut0 (
    .clk(clk), .rst_(rst_), .stall(stall), .flush(flush), .pc_flush(pc_flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .pc(pc0), .pred_taken(pt0), .pred_target(ptg0)
  );

  pc_gen_btb #(.XLEN(32), .RESET_VEC(32'hFFFF_FFFC), .BTB_IDX_BITS(4)) dut1 (
    .clk(clk), .rst_(rst_), .stall(stall), .flush(flush), .pc_flush(pc_flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .pc(pc1), .pred_taken(pt1), .pred_target(ptg1)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a table of 16 entries addressed by word address mod 16
  longint m_rv [2] = '{64'h0, 64'hFFFF_FFFC};
  longint m_pc [2];
  bit     m_v  [2][16];
  longint m_tag[2][16];
  longint m_tgt[2][16];
  int     m_ctr[2][16];

  function automatic bit m_pred(int k);
    int i;
    i = int'((m_pc[k] / 4) % 16);
    return m_v[k][i] && (m_tag[k][i] == m_pc[k] / 64) && (m_ctr[k][i] >= 2);
  endfunction

  function automatic longint m_pred_tgt(int k);
    int i;
    i = int'((m_pc[k] / 4) % 16);
    return m_pred(k) ? m_tgt[k][i] : 64'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_step(int k);
    bit     pt;
    longint pt_tgt;
    int     ui;
    bit     uhit;
    pt     = m_pred(k);
    pt_tgt = m_pred_tgt(k);
    if (rst_) begin
      m_pc[k] = m_rv[k];
      for (int j = 0; j < 16; j++) begin
        m_v[k][j]   = 1'b0;
        m_ctr[k][j] = 1;
      end
    end else begin
      if (flush)      m_pc[k] = longint'(pc_flush) & 64'hFFFF_FFFC;
      else if (stall) m_pc[k] = m_pc[k];
      else if (pt)    m_pc[k] = pt_tgt;
      else            m_pc[k] = (m_pc[k] + 4) % 64'h1_0000_0000;
      if (upd_valid) begin
        ui   = int'((longint'(upd_pc) / 4) % 16);
        uhit = m_v[k][ui] && (m_tag[k][ui] == longint'(upd_pc) / 64);
        if (uhit) begin
          if (upd_taken) begin
            m_ctr[k][ui] = (m_ctr[k][ui] == 3) ? 3 : m_ctr[k][ui] + 1;
            m_tgt[k][ui] = longint'(upd_target) & 64'hFFFF_FFFC;
          end else begin
            m_ctr[k][ui] = (m_ctr[k][ui] == 0) ? 0 : m_ctr[k][ui] - 1;
          end
        end else if (upd_taken) begin
          m_v[k][ui]   = 1'b1;
          m_tag[k][ui] = longint'(upd_pc) / 64;
          m_tgt[k][ui] = longint'(upd_target) & 64'hFFFF_FFFC;
          m_ctr[k][ui] = 2;
        end
      end
    end
  endtask

  // Driver: advance one clock and compare both instances with the model
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    chk("pc0", pc0, m_pc[0][31:0]);
    chk("pred_taken0", {31'h0, pt0}, {31'h0, m_pred(0)});
    chk("pred_target0", ptg0, m_pred_tgt(0) & 64'hFFFF_FFFF);
    chk("pc1", pc1, m_pc[1][31:0]);
    chk("pred_taken1", {31'h0, pt1}, {31'h0, m_pred(1)});
    chk("pred_target1", ptg1, m_pred_tgt(1) & 64'hFFFF_FFFF);
  endtask

  task automatic set_upd(input bit v, input logic [31:0] a, input bit t, input logic [31:0] tgt);
    upd_valid  = v;
    upd_pc     = a;
    upd_taken  = t;
    upd_target = tgt;
  endtask

  task automatic redirect(input logic [31:0] a);
    flush    = 1'b1;
    pc_flush = a;
    tick();
    flush    = 1'b0;
  endtask

  initial begin
    rst_ = 1'b1; stall = 1'b0; flush = 1'b0; pc_flush = '0;
    set_upd(1'b0, '0, 1'b0, '0);

    // Reset then sequential fetch
    tick(); tick();
    chk("reset_pc", pc0, 32'h0);
    chk("reset_pred", {31'h0, pt0}, 32'h0);
    rst_ = 1'b0;
    tick(); chk("seq_4", pc0, 32'h4);
    tick(); chk("seq_8", pc0, 32'h8);

    // Stall holds, flush beats stall and drops the low bits
    stall = 1'b1;
    tick(); tick(); chk("stall_hold", pc0, 32'h8);
    flush = 1'b1; pc_flush = 32'h103;
    tick(); chk("flush_over_stall", pc0, 32'h100);
    flush = 1'b0; stall = 1'b0;
    tick(); chk("after_flush", pc0, 32'h104);

    // Allocate and predict
    set_upd(1'b1, 32'h10, 1'b1, 32'h40);
    tick();
    set_upd(1'b0, '0, 1'b0, '0);
    redirect(32'h10);
    chk("alloc_pred", {31'h0, pt0}, 32'h1);
    chk("alloc_tgt", ptg0, 32'h40);
    tick(); chk("follow_pred", pc0, 32'h40);

    // Train down to strongly not-taken, then back up to saturation
    set_upd(1'b1, 32'h10, 1'b0, 32'h0);
    tick(); tick();
    set_upd(1'b0, '0, 1'b0, '0);
    redirect(32'h10);
    chk("snt_pred", {31'h0, pt0}, 32'h0);
    tick(); chk("snt_seq", pc0, 32'h14);
    set_upd(1'b1, 32'h10, 1'b1, 32'h40);
    repeat (4) tick();
    set_upd(1'b0, '0, 1'b0, '0);
    redirect(32'h10);
    chk("st_pred", {31'h0, pt0}, 32'h1);

    // Alias replacement with a same-cycle lookup at 0x50
    redirect(32'h50);
    chk("alias_miss_before", {31'h0, pt0}, 32'h0);
    set_upd(1'b1, 32'h50, 1'b1, 32'h80);
    tick(); chk("same_cycle_old", pc0, 32'h54);
    set_upd(1'b0, '0, 1'b0, '0);
    redirect(32'h50);
    chk("alias_new_tgt", ptg0, 32'h80);
    tick(); chk("alias_follow", pc0, 32'h80);
    redirect(32'h10);
    chk("alias_evicted", {31'h0, pt0}, 32'h0);
    tick(); chk("alias_seq", pc0, 32'h14);

    // Wrap from the top reset vector, then reset overriding flush and update
    rst_ = 1'b1;
    tick(); chk("wrap_rv", pc1, 32'hFFFF_FFFC);
    rst_ = 1'b0;
    tick(); chk("wrap_zero", pc1, 32'h0);
    rst_ = 1'b1; flush = 1'b1; pc_flush = 32'h200;
    set_upd(1'b1, 32'h10, 1'b1, 32'h40);
    tick(); chk("rst_override", pc0, 32'h0);
    rst_ = 1'b0; flush = 1'b0;
    set_upd(1'b0, '0, 1'b0, '0);
    redirect(32'h10);
    chk("rst_btb_empty", {31'h0, pt0}, 32'h0);
    tick(); chk("rst_btb_seq", pc0, 32'h14);

    // Randomized traffic in a small address window to force hits and aliases
    for (int n = 0; n < 400; n++) begin
      rst_     = ($urandom_range(0, 99) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      pc_flush = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, 255));
      set_upd($urandom_range(0, 1) == 1, 32'($urandom_range(0, 255)),
              $urandom_range(0, 2) != 0, 32'($urandom_range(0, 255)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
